// File: rtl/mram_ctrl_seq.sv
// ============================================================================
// Module  : mram_ctrl_seq
// Brief   : One MRAM access per start request: serial shift-in, strobes,
//           read wait/load, serial shift-out, with a start/busy/done handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mram_ctrl_seq #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 20,
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op_write,
    input  logic [1:0] byte_sel,
    output logic       busy,
    output logic       done,
    output logic       data_en,
    output logic       addr_en,
    output logic       send_data,
    output logic       load,
    output logic       rd_shift_en,
    output logic       chip_en,
    output logic       write_en,
    output logic       out_en,
    output logic       lower_byte_en,
    output logic       upper_byte_en
);

    localparam int c_MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_MAX_TW  = ((RD_WAIT + 1) > WR_PULSE) ? (RD_WAIT + 1) : WR_PULSE;
    localparam int c_CNT_MAX = (c_MAX_AD > c_MAX_TW) ? c_MAX_AD : c_MAX_TW;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_LAST_IN_WR = c_CW'(c_MAX_AD - 1);
    localparam logic [c_CW-1:0] c_LAST_IN_RD = c_CW'(ADDR_W - 1);
    localparam logic [c_CW-1:0] c_LAST_WR    = c_CW'(WR_PULSE - 1);
    localparam logic [c_CW-1:0] c_LAST_ACC   = c_CW'(RD_WAIT);
    localparam logic [c_CW-1:0] c_LAST_OUT   = c_CW'(DATA_W - 1);
    localparam logic [c_CW-1:0] c_ADDR_N     = c_CW'(ADDR_W);
    localparam logic [c_CW-1:0] c_DATA_N     = c_CW'(DATA_W);
    localparam logic [11:0]     c_OUT_IDLE   = 12'h01F;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_WR_STROBE = 3'd2,
        S_RD_ACCESS = 3'd3,
        S_RD_LOAD   = 3'd4,
        S_SHIFT_OUT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t            r_state, w_nxt_state;
    logic [c_CW-1:0]   r_cnt, w_nxt_cnt;
    logic              r_wr, w_nxt_wr;
    logic [1:0]        r_sel, w_nxt_sel;
    logic [11:0]       r_out, w_out;

    logic w_busy, w_done, w_data_en, w_addr_en, w_send, w_load, w_sh;
    logic w_ce, w_we, w_oe, w_lb, w_ub;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + c_CW'(1);
        w_nxt_wr    = r_wr;
        w_nxt_sel   = r_sel;
        case (r_state)
            S_IDLE: begin
                w_nxt_cnt = '0;
                if (start && (byte_sel != 2'b00)) begin
                    w_nxt_state = S_SHIFT_IN;
                    w_nxt_wr    = op_write;
                    w_nxt_sel   = byte_sel;
                end
            end
            S_SHIFT_IN: begin
                if (r_cnt == (r_wr ? c_LAST_IN_WR : c_LAST_IN_RD)) begin
                    w_nxt_state = r_wr ? S_WR_STROBE : S_RD_ACCESS;
                    w_nxt_cnt   = '0;
                end
            end
            S_WR_STROBE: begin
                if (r_cnt == c_LAST_WR) begin
                    w_nxt_state = S_DONE;
                    w_nxt_cnt   = '0;
                end
            end
            S_RD_ACCESS: begin
                if (r_cnt == c_LAST_ACC) begin
                    w_nxt_state = S_RD_LOAD;
                    w_nxt_cnt   = '0;
                end
            end
            S_RD_LOAD: begin
                w_nxt_state = S_SHIFT_OUT;
                w_nxt_cnt   = '0;
            end
            S_SHIFT_OUT: begin
                if (r_cnt == c_LAST_OUT) begin
                    w_nxt_state = S_DONE;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_data_en = 1'b0;
        w_addr_en = 1'b0;
        w_send    = 1'b0;
        w_load    = 1'b0;
        w_sh      = 1'b0;
        w_ce      = 1'b1;
        w_we      = 1'b1;
        w_oe      = 1'b1;
        w_lb      = 1'b1;
        w_ub      = 1'b1;
        case (w_nxt_state)
            S_SHIFT_IN: begin
                w_busy    = 1'b1;
                w_addr_en = (w_nxt_cnt < c_ADDR_N);
                w_data_en = w_nxt_wr && (w_nxt_cnt < c_DATA_N);
            end
            S_WR_STROBE: begin
                w_busy = 1'b1;
                w_send = 1'b1;
                w_ce   = 1'b0;
                w_we   = 1'b0;
                w_lb   = ~w_nxt_sel[0];
                w_ub   = ~w_nxt_sel[1];
            end
            S_RD_ACCESS: begin
                w_busy = 1'b1;
                w_send = 1'b1;
                w_ce   = 1'b0;
                w_oe   = 1'b0;
                w_lb   = ~w_nxt_sel[0];
                w_ub   = ~w_nxt_sel[1];
            end
            S_RD_LOAD: begin
                w_busy = 1'b1;
                w_load = 1'b1;
                w_ce   = 1'b0;
                w_oe   = 1'b0;
                w_lb   = ~w_nxt_sel[0];
                w_ub   = ~w_nxt_sel[1];
            end
            S_SHIFT_OUT: begin
                w_busy = 1'b1;
                w_sh   = 1'b1;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
        w_out = {w_busy, w_done, w_data_en, w_addr_en, w_send, w_load, w_sh,
                 w_ce, w_we, w_oe, w_lb, w_ub};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_sel   <= 2'b00;
            r_out   <= c_OUT_IDLE;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_wr    <= w_nxt_wr;
            r_sel   <= w_nxt_sel;
            r_out   <= w_out;
        end
    end

    assign {busy, done, data_en, addr_en, send_data, load, rd_shift_en,
            chip_en, write_en, out_en, lower_byte_en, upper_byte_en} = r_out;

endmodule

`default_nettype wire

// File: doc/mram_ctrl_seq.md
Name: mram_ctrl_seq

Overview:
Parametrised successor to the MRAM control sequencer. It sequences one MRAM access per start request: serial address/data shift-in, the chip/write/output/byte strobes, read access wait, load, and serial shift-out. Unlike the previous free-running counter design, it uses an explicit FSM with a start/busy/done handshake, latched command fields, configurable widths and wait states, and a true nop. It sits between the host-side serial front end and the STP/PTS shift modules plus the MRAM pins.

Parameters:
DATA_W, 16, MRAM data word width (bits shifted in for a write and out for a read); >=1
ADDR_W, 20, MRAM address width (bits shifted into the address STP); >=1
RD_WAIT, 1, extra access cycles between read strobe assertion and load; >=0
WR_PULSE, 1, cycles the write strobe is held low; >=1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
op_write  in  1  1 = write, 0 = read; latched on accept
byte_sel  in  2  bit0 = lower byte, bit1 = upper byte; 00 = nop; latched on accept
busy  out  1  high from the cycle after accept through the DONE cycle
done  out  1  one-cycle completion pulse
data_en  out  1  data STP shift enable
addr_en  out  1  address STP shift enable
send_data  out  1  drive parallel addr/data to MRAM pins
load  out  1  PTS parallel load from MRAM
rd_shift_en  out  1  PTS shift enable
chip_en  out  1  active low
write_en  out  1  active low
out_en  out  1  active low
lower_byte_en  out  1  active low
upper_byte_en  out  1  active low

Behaviour:
- All outputs are registered. Reset values: busy, done, data_en, addr_en, send_data, load and rd_shift_en are 0. chip_en, write_en, out_en, lower_byte_en and upper_byte_en are 1.
- States: IDLE, SHIFT_IN, WR_STROBE, RD_ACCESS, RD_LOAD, SHIFT_OUT, DONE. A counter is sized for max(ADDR_W, DATA_W, RD_WAIT+1, WR_PULSE) and cleared on every state entry.
- IDLE: a request is accepted when start=1 and byte_sel!=00. On accept, latch op_write and byte_sel and go to SHIFT_IN. If start=1 with byte_sel=00, stay in IDLE: no busy, no done, no strobes.
- SHIFT_IN: lasts L = max(ADDR_W, op_write ? DATA_W : 0) cycles.
  - addr_en=1 for the first ADDR_W cycles.
  - data_en=1 for the first DATA_W cycles, writes only; data_en stays 0 on reads.
  - Then go to WR_STROBE (write) or RD_ACCESS (read).
- WR_STROBE: lasts WR_PULSE cycles. send_data=1, chip_en=0, write_en=0, out_en=1, lower_byte_en=~sel[0], upper_byte_en=~sel[1]. Then go to DONE.
- RD_ACCESS: lasts 1+RD_WAIT cycles. send_data=1, chip_en=0, write_en=1, out_en=0, byte enables as above. Then go to RD_LOAD.
- RD_LOAD: 1 cycle. Read strobes stay asserted, send_data=0, load=1. Then go to SHIFT_OUT.
- SHIFT_OUT: lasts DATA_W cycles. rd_shift_en=1, MRAM strobes deasserted. Then go to DONE.
- DONE: 1 cycle. done=1, busy=1, all strobes deasserted. Then go to IDLE; busy=0 on the next cycle.
- Outside the states above, every output holds its reset value.
- Latency is counted in cycles after the accept edge. Done is high in cycle:
  - write: L+WR_PULSE+1; defaults give 22
  - read: ADDR_W+RD_WAIT+DATA_W+3; defaults give 40
- Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.
- start while busy is ignored, not queued. byte_sel and op_write changes while busy have no effect.
- rst asserted in any state: on the next edge, return to IDLE with all outputs at reset values. Strobes must never remain low across reset.
- write_en=0 and out_en=0 are never asserted in the same cycle. load and rd_shift_en are never high in the same cycle.

Test Plan:
1. Defaults, start with op_write=1, byte_sel=11 -> addr_en high 20 cycles; data_en high for the first 16 of those cycles; 1 cycle with chip_en=0, write_en=0 and both byte enables 0; done pulses in cycle 22.
2. Defaults, read with byte_sel=01 -> chip_en/out_en low for 2 cycles plus the load cycle, lower_byte_en=0, upper_byte_en=1; load high 1 cycle; rd_shift_en high 16 cycles; done in cycle 40.
3. start with byte_sel=00 -> busy, done and all strobes stay at idle values; a following valid start is accepted normally.
4. A second start pulse mid-read, plus byte_sel toggled -> ignored; strobes follow the latched byte_sel; exactly one done; a start in the cycle after done is accepted.
5. rst asserted during RD_ACCESS -> next cycle chip_en=out_en=1, busy=0, all enables 0; a subsequent write completes in 22 cycles.
6. DATA_W=8, ADDR_W=12, RD_WAIT=3, WR_PULSE=2 -> write done in cycle 15 with write_en low 2 cycles; read done in cycle 26 with 4 access cycles.
